// File: rtl/vec_cfg_pkg.sv
// Shared vector-configuration definitions: default VLEN, the legal SEW/LMUL
// encodings, AVL/VL width and the strip-sequencer state encoding.
package vec_cfg_pkg;

  localparam int VLEN_DEF = 128;
  localparam int AVL_W    = 9;
  localparam int N_SEW    = 5;
  localparam int N_LMUL   = 5;

  localparam logic [7:0] LEGAL_SEW  [N_SEW]  = '{8'd8, 8'd16, 8'd32, 8'd64, 8'd128};
  localparam logic [4:0] LEGAL_LMUL [N_LMUL] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_DONE,
    ST_ERR
  } seq_state_e;

  function automatic logic sew_legal(input logic [7:0] sew);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_SEW; i++) begin
      if (sew == LEGAL_SEW[i]) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic lmul_legal(input logic [4:0] lmul);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LMUL; i++) begin
      if (lmul == LEGAL_LMUL[i]) ok = 1'b1;
    end
    return ok;
  endfunction

  // log2(SEW); the legal list starts at 8 = 2**3 and doubles each entry.
  function automatic logic [2:0] sew_shift(input logic [7:0] sew);
    logic [2:0] sh;
    sh = 3'd0;
    for (int i = 0; i < N_SEW; i++) begin
      if (sew == LEGAL_SEW[i]) sh = 3'(i + 3);
    end
    return sh;
  endfunction

endpackage

// File: rtl/vl_setup.sv
// Combinational vector-length calculator: vl = min(avl, vlmax) and the
// remaining AVL after one strip, flagged invalid for illegal SEW/LMUL.
module vl_setup
  import vec_cfg_pkg::*;
#(
  parameter int VLEN = VLEN_DEF
) (
  input  logic [7:0]       sew,
  input  logic [4:0]       lmul,
  input  logic [AVL_W-1:0] avl,
  output logic             valid,
  output logic [AVL_W-1:0] vl,
  output logic [AVL_W-1:0] new_AVL
);

  logic [AVL_W-1:0] vlmax;

  always_comb begin
    valid   = sew_legal(sew) && lmul_legal(lmul);
    vlmax   = '0;
    if (valid) begin
      vlmax = AVL_W'((32'(VLEN) >> sew_shift(sew)) * 32'(lmul));
    end
    vl      = (avl < vlmax) ? avl : vlmax;
    new_AVL = avl - vl;
  end

endmodule

// File: rtl/vl_strip_sequencer.sv
// Strip-mining controller: splits one (SEW, LMUL, AVL) request into strips of
// at most vlmax elements and hands each to the execution stage via valid/ready.
module vl_strip_sequencer
  import vec_cfg_pkg::*;
#(
  parameter int VLEN = VLEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_sew,
  input  logic [4:0]       req_lmul,
  input  logic [AVL_W-1:0] req_avl,
  output logic             strip_valid,
  input  logic             strip_ready,
  output logic [AVL_W-1:0] strip_vl,
  output logic [AVL_W-1:0] strip_offset,
  output logic             strip_last,
  input  logic             flush,
  output logic             done,
  output logic             err
);

  seq_state_e       state_q,   state_d;
  logic [7:0]       sew_q,     sew_d;
  logic [4:0]       lmul_q,    lmul_d;
  logic [AVL_W-1:0] avl_rem_q, avl_rem_d;
  logic [AVL_W-1:0] offset_q,  offset_d;

  logic             setup_valid;
  logic [AVL_W-1:0] setup_vl;
  logic [AVL_W-1:0] setup_new_avl;
  logic             issuing;

  vl_setup #(
    .VLEN(VLEN)
  ) u_vl_setup (
    .sew    (sew_q),
    .lmul   (lmul_q),
    .avl    (avl_rem_q),
    .valid  (setup_valid),
    .vl     (setup_vl),
    .new_AVL(setup_new_avl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sew_q     <= '0;
      lmul_q    <= '0;
      avl_rem_q <= '0;
      offset_q  <= '0;
    end else begin
      state_q   <= state_d;
      sew_q     <= sew_d;
      lmul_q    <= lmul_d;
      avl_rem_q <= avl_rem_d;
      offset_q  <= offset_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sew_d     = sew_q;
    lmul_d    = lmul_q;
    avl_rem_d = avl_rem_q;
    offset_d  = offset_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sew_d     = req_sew;
          lmul_d    = req_lmul;
          avl_rem_d = req_avl;
          offset_d  = '0;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!setup_valid) begin
          state_d = ST_ERR;
        end else if (avl_rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (strip_ready) begin
          avl_rem_d = setup_new_avl;
          offset_d  = offset_q + setup_vl;
          if (setup_new_avl == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over any same-cycle handshake; the request context is frozen.
    if (flush && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      sew_d     = sew_q;
      lmul_d    = lmul_q;
      avl_rem_d = avl_rem_q;
      offset_d  = offset_q;
    end
  end

  always_comb begin
    issuing      = (state_q == ST_ISSUE);
    req_ready    = (state_q == ST_IDLE);
    strip_valid  = issuing;
    strip_vl     = issuing ? setup_vl : '0;
    strip_offset = issuing ? offset_q : '0;
    strip_last   = issuing && (setup_new_avl == '0);
    done         = (state_q == ST_DONE);
    err          = (state_q == ST_ERR);
  end

endmodule
